// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

    localparam int          FETCH_DEPTH  = 4;
    localparam logic [31:0] FETCH_STRIDE = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched instruction pairs with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_pair_t                push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output fetch_pair_t                head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_pair_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en;
    logic          pop_en;

    // Flush wins over both operations; a pop of an empty buffer is ignored.
    assign push_en = push && !flush;
    assign pop_en  = pop && !flush && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from count_q alone.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch request register, stall/flush policy and decode-side output gating
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_addr,
    input  logic [31:0] imem_rdata0,
    input  logic [31:0] imem_rdata1,
    input  logic        flush,
    input  logic        dec_ready,
    output logic        stall,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_inst0,
    output logic [31:0] dec_inst1
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          fetch_vld_q, fetch_vld_d;
    logic [CW-1:0] count;
    fetch_pair_t   push_pair;
    fetch_pair_t   head;
    logic          pop;

    // Threshold is one below full: the pair already requested from imem
    // always lands, so it must have a free slot waiting for it.
    assign stall     = !flush && (count >= CW'(DEPTH - 1));
    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready;

    always_comb begin
        fetch_pc_d      = pc_addr;
        fetch_vld_d     = !stall && !flush;
        push_pair.pc    = fetch_pc_q;
        push_pair.inst0 = imem_rdata0;
        push_pair.inst1 = imem_rdata1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= '0;
            fetch_vld_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            fetch_vld_q <= fetch_vld_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fetch_vld_q),
        .push_data (push_pair),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign dec_pc    = dec_valid ? head.pc    : '0;
    assign dec_inst0 = dec_valid ? head.inst0 : '0;
    assign dec_inst1 = dec_valid ? head.inst1 : '0;

endmodule
